// File: rtl/capture_buffer_reader.sv
// ============================================================================
// capture_buffer_reader
//   Read-side initiator for capture_buffer: sweeps a wrap-around address range
//   one read at a time and streams I/Q samples through a 2-entry output FIFO.
//   Optional continuous looping: CAPTURE_BUFFER_READER_LOOP_EN.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module capture_buffer_reader #(
  parameter int BUFFER_LENGTH = 4096,
  parameter int INDEX_BITS    = 12,
  parameter int I_BITS        = 12,
  parameter int Q_BITS        = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [INDEX_BITS-1:0]    start_addr,
  input  logic [INDEX_BITS:0]      length,
  input  logic                     abort,
`ifdef CAPTURE_BUFFER_READER_LOOP_EN
  input  logic                     loop,
`endif
  output logic [INDEX_BITS-1:0]    m_axi_raddr,
  output logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  input  logic                     s_axi_rready,
  input  logic                     s_axi_rvalid,
  input  logic signed [I_BITS-1:0] i,
  input  logic signed [Q_BITS-1:0] q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [I_BITS-1:0] out_i,
  output logic signed [Q_BITS-1:0] out_q,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int                    ENTRY_W   = I_BITS + Q_BITS + 1;
  localparam logic [INDEX_BITS:0]   LEN_MAX   = (INDEX_BITS+1)'(BUFFER_LENGTH);
  localparam logic [INDEX_BITS:0]   LEN_ONE   = (INDEX_BITS+1)'(1);
  localparam logic [INDEX_BITS-1:0] ADDR_LAST = INDEX_BITS'(BUFFER_LENGTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]            state;
  logic [INDEX_BITS-1:0] cur_addr;
  logic [INDEX_BITS:0]   remaining;
  logic [ENTRY_W-1:0]    fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;
`ifdef CAPTURE_BUFFER_READER_LOOP_EN
  logic [INDEX_BITS-1:0] loop_addr;
  logic [INDEX_BITS:0]   loop_len;
`endif

  logic [INDEX_BITS-1:0] clamp_addr;
  logic [INDEX_BITS:0]   clamp_len;
  logic [INDEX_BITS-1:0] next_addr;
  logic [ENTRY_W-1:0]    head;
  logic                  last_beat;
  logic                  push;
  logic                  pop;
  logic                  flush;

  always_comb begin
    clamp_len  = (length > LEN_MAX) ? LEN_MAX : length;
    clamp_addr = ({1'b0, start_addr} >= LEN_MAX) ? '0 : start_addr;
    next_addr  = (cur_addr == ADDR_LAST) ? '0 : cur_addr + 1'b1;
    last_beat  = (remaining == LEN_ONE);
    head       = fifo_mem[rd_ptr];
  end

  // A response arriving in the same cycle as abort is discarded with the rest.
  assign push  = (state == S_DATA) && s_axi_rvalid && !abort;
  assign pop   = out_valid && out_ready;
  assign flush = abort && (state != S_IDLE);

  // Issuing only with at most one entry occupied leaves room for the reply.
  assign m_axi_raddr  = cur_addr;
  assign m_axi_rvalid = (state == S_ADDR) && (fifo_count <= 2'd1);
  assign m_axi_rready = (state == S_DATA) || (state == S_FLUSH);
  assign busy         = (state != S_IDLE);
  assign out_valid    = (fifo_count != 2'd0);
  assign out_last     = out_valid && head[ENTRY_W-1];
  assign out_i        = out_valid ? head[I_BITS+Q_BITS-1:Q_BITS] : '0;
  assign out_q        = out_valid ? head[Q_BITS-1:0] : '0;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {last_beat, i, q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else if (flush) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      done      <= 1'b0;
`ifdef CAPTURE_BUFFER_READER_LOOP_EN
      loop_addr <= '0;
      loop_len  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr  <= clamp_addr;
            remaining <= clamp_len;
`ifdef CAPTURE_BUFFER_READER_LOOP_EN
            loop_addr <= clamp_addr;
            loop_len  <= clamp_len;
`endif
            state     <= (clamp_len == '0) ? S_DRAIN : S_ADDR;
          end
        end
        S_ADDR: begin
          if (abort)                             state <= S_IDLE;
          else if (m_axi_rvalid && s_axi_rready) state <= S_DATA;
        end
        S_DATA: begin
          if (abort) begin
            state <= s_axi_rvalid ? S_IDLE : S_FLUSH;
          end else if (s_axi_rvalid) begin
            cur_addr  <= next_addr;
            remaining <= remaining - LEN_ONE;
            if (last_beat) begin
`ifdef CAPTURE_BUFFER_READER_LOOP_EN
              if (loop) begin
                cur_addr  <= loop_addr;
                remaining <= loop_len;
                state     <= S_ADDR;
              end else begin
                state <= S_DRAIN;
              end
`else
              state <= S_DRAIN;
`endif
            end else begin
              state <= S_ADDR;
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (fifo_count == 2'd0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (s_axi_rvalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_capture_buffer_reader.sv
// Self-checking bench for capture_buffer_reader (BUFFER_LENGTH=8) with a
// responder returning {addr*10, -addr} and a sample scoreboard.
`timescale 1ns/1ps
`default_nettype none

module tb_capture_buffer_reader;

  localparam int BL = 8;
  localparam int IB = 3;
  localparam int IW = 12;
  localparam int QW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [IB-1:0] start_addr = '0;
  logic [IB:0]   length = '0;
  logic s_axi_rready = 1'b1;
  logic s_axi_rvalid = 1'b0;
  logic signed [IW-1:0] i_d = '0;
  logic signed [QW-1:0] q_d = '0;
  logic out_ready = 1'b0;
`ifdef CAPTURE_BUFFER_READER_LOOP_EN
  logic loop = 1'b0;
`endif

  logic [IB-1:0] m_axi_raddr;
  logic m_axi_rvalid, m_axi_rready, out_valid, out_last, busy, done;
  logic signed [IW-1:0] out_i;
  logic signed [QW-1:0] out_q;

  capture_buffer_reader #(
    .BUFFER_LENGTH(BL), .INDEX_BITS(IB), .I_BITS(IW), .Q_BITS(QW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort),
`ifdef CAPTURE_BUFFER_READER_LOOP_EN
    .loop(loop),
`endif
    .m_axi_raddr(m_axi_raddr), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .s_axi_rready(s_axi_rready),
    .s_axi_rvalid(s_axi_rvalid), .i(i_d), .q(q_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i),
    .out_q(out_q), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [IW-1:0] si;
    logic [QW-1:0] sq;
  } samp_t;

  typedef struct {
    logic [IB-1:0] sa;
    logic [IB:0]   len;
    int            stall;
    int            nreads;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  samp_t sb[$];
  int raddr_log[$];
  int exp_addr[$];
  int done_cnt = 0, done_edge = -1, last_pop_edge = -1, pop_cnt = 0, start_edge = 0;
  int pend = 0, pend_addr = 0, wait_cnt = 0, rsp_delay = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder: one outstanding read, reply after rsp_delay cycles.
  always @(negedge clk) begin
    s_axi_rvalid = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend != 0 && wait_cnt == 0) begin
        s_axi_rvalid = 1'b1;
        i_d  = IW'(pend_addr * 10);
        q_d  = QW'(-pend_addr);
        pend = 0;
      end else if (pend != 0) begin
        wait_cnt--;
      end
      if (m_axi_rvalid && s_axi_rready) begin
        pend      = 1;
        pend_addr = int'(m_axi_raddr);
        wait_cnt  = rsp_delay;
        raddr_log.push_back(pend_addr);
      end
    end
  end

  // Output monitor: compares popped samples against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: got %0d/%0d expected none", out_i, out_q);
      end else begin
        samp_t e;
        e = sb.pop_front();
        check("sample", {out_last, out_i, out_q}, e);
      end
      pop_cnt++;
      if (out_last) last_pop_edge = cyc + 1;
    end
    if (rst_n && done) begin
      done_cnt++;
      done_edge = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int sa, input int n);
    samp_t s;
    for (int k = 0; k < n; k++) begin
      int a;
      a = (sa + k) % BL;
      s.last = (k == n - 1);
      s.si   = IW'(a * 10);
      s.sq   = QW'(-a);
      sb.push_back(s);
      exp_addr.push_back(a);
    end
  endtask

  task automatic clear_logs();
    sb.delete();
    exp_addr.delete();
    raddr_log.delete();
    done_cnt = 0;
    done_edge = -1;
    last_pop_edge = -1;
    pop_cnt = 0;
  endtask

  task automatic start_sweep(input int sa, input int len);
    start_addr = IB'(sa);
    length     = (IB+1)'(len);
    start      = 1'b1;
    start_edge = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int t = 0; t < 300 && done_cnt == 0; t++) tick();
    if (done_cnt == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end
    tick();
  endtask

  task automatic check_reads(input string name);
    int mism;
    mism = 0;
    check({name, "_nreads"}, raddr_log.size(), exp_addr.size());
    for (int k = 0; k < raddr_log.size() && k < exp_addr.size(); k++)
      if (raddr_log[k] != exp_addr[k]) mism++;
    check({name, "_raddr_seq"}, mism, 0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{3'd0, 4'd8,  0, 8};   // full sweep
    vecs[1] = '{3'd6, 4'd4,  0, 4};   // wrap 6,7,0,1
    vecs[2] = '{3'd0, 4'd5, 10, 5};   // backpressure
    vecs[3] = '{3'd3, 4'd0,  0, 0};   // empty sweep
    vecs[4] = '{3'd2, 4'd12, 0, 8};   // clamp to buffer length

    repeat (3) tick();
    check("reset_outputs",
          {m_axi_raddr, m_axi_rvalid, m_axi_rready, out_valid, out_i, out_q,
           out_last, busy, done}, 0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      clear_logs();
      push_sweep(int'(vecs[v].sa), vecs[v].nreads);
      out_ready = (vecs[v].stall == 0);
      start_sweep(int'(vecs[v].sa), int'(vecs[v].len));
      check($sformatf("v%0d_busy_after_start", v), busy, 1);
      if (vecs[v].stall > 0) begin
        repeat (vecs[v].stall - 1) tick();
        check($sformatf("v%0d_reads_while_full", v), raddr_log.size(), 2);
        check($sformatf("v%0d_valid_while_stalled", v), out_valid, 1);
        out_ready = 1'b1;
      end
      wait_done($sformatf("v%0d", v));
      check($sformatf("v%0d_sb_empty", v), sb.size(), 0);
      check($sformatf("v%0d_done_count", v), done_cnt, 1);
      check($sformatf("v%0d_busy_after_done", v), busy, 0);
      check_reads($sformatf("v%0d", v));
      if (vecs[v].nreads > 0)
        check($sformatf("v%0d_done_edge", v), done_edge, last_pop_edge + 1);
      else
        check($sformatf("v%0d_done_within_2", v), (done_edge - start_edge) <= 2, 1);
    end

    // Start while busy is ignored.
    clear_logs();
    push_sweep(0, 3);
    out_ready = 1'b1;
    start_sweep(0, 3);
    tick();
    start_sweep(5, 8);
    wait_done("busy_start");
    check("busy_start_sb_empty", sb.size(), 0);
    check_reads("busy_start");
    check("busy_start_done_count", done_cnt, 1);

    // Abort while a delayed response is outstanding.
    clear_logs();
    rsp_delay = 3;
    start_sweep(2, 4);
    for (int t = 0; t < 50 && !m_axi_rready; t++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_rready_held", m_axi_rready, 1);
    check("abort_busy_in_flush", busy, 1);
    check("abort_out_valid", out_valid, 0);
    for (int t = 0; t < 20 && !s_axi_rvalid; t++) tick();
    if (!s_axi_rvalid) tick();
    check("abort_rready_after_rsp", m_axi_rready, 0);
    check("abort_busy_after_rsp", busy, 0);
    repeat (4) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_out_valid_after", out_valid, 0);
    check("abort_no_new_reads", raddr_log.size(), 1);
    rsp_delay = 0;

    // Reset in the middle of a sweep, then a clean sweep.
    clear_logs();
    push_sweep(0, 8);
    start_sweep(0, 8);
    for (int t = 0; t < 100 && pop_cnt < 3; t++) tick();
    rst_n = 1'b0;
    tick();
    check("midreset_outputs",
          {m_axi_raddr, m_axi_rvalid, m_axi_rready, out_valid, out_i, out_q,
           out_last, busy, done}, 0);
    rst_n = 1'b1;
    tick();
    clear_logs();
    push_sweep(4, 3);
    start_sweep(4, 3);
    wait_done("post_reset");
    check("post_reset_sb_empty", sb.size(), 0);
    check_reads("post_reset");
    check("post_reset_done_count", done_cnt, 1);

`ifdef CAPTURE_BUFFER_READER_LOOP_EN
    clear_logs();
    loop = 1'b1;
    push_sweep(0, 3);
    push_sweep(0, 3);
    start_sweep(0, 3);
    for (int t = 0; t < 100 && raddr_log.size() < 4; t++) tick();
    loop = 1'b0;
    wait_done("loop");
    check("loop_sb_empty", sb.size(), 0);
    check_reads("loop");
    check("loop_done_count", done_cnt, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
